// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, RV32 opcode constants and decoded-record type
// Purpose: single source of ALU operation codes for the decode stage and the ALU,
//          plus the decoded-record struct carried through the skid buffer.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU operation codes (6 bits)
  localparam logic [5:0] ALU_NOP   = 6'd0;
  localparam logic [5:0] ALU_ADDI  = 6'd5;
  localparam logic [5:0] ALU_SLLI  = 6'd6;
  localparam logic [5:0] ALU_SLTI  = 6'd7;
  localparam logic [5:0] ALU_SLTIU = 6'd8;
  localparam logic [5:0] ALU_XORI  = 6'd9;
  localparam logic [5:0] ALU_SRLI  = 6'd10;
  localparam logic [5:0] ALU_SRAI  = 6'd11;
  localparam logic [5:0] ALU_ORI   = 6'd12;
  localparam logic [5:0] ALU_ANDI  = 6'd13;
  localparam logic [5:0] ALU_ADD   = 6'd18;
  localparam logic [5:0] ALU_SUB   = 6'd19;
  localparam logic [5:0] ALU_SLL   = 6'd20;
  localparam logic [5:0] ALU_SLT   = 6'd21;
  localparam logic [5:0] ALU_SLTU  = 6'd22;
  localparam logic [5:0] ALU_XOR   = 6'd23;
  localparam logic [5:0] ALU_SRL   = 6'd24;
  localparam logic [5:0] ALU_SRA   = 6'd25;
  localparam logic [5:0] ALU_OR    = 6'd26;
  localparam logic [5:0] ALU_AND   = 6'd27;

  // RV32I major opcodes and funct7 patterns
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [5:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } dec_rec_t;

  localparam int DEC_REC_W = $bits(dec_rec_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// rtl/alu_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
// Ports: in_valid/in_ready/in_instr/in_pc (fetch side), out_valid/out_ready/out_* (execute side).
// master = the environment (fetch + execute), slave = the decode stage.
interface alu_decode_stage_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_alu_op;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_use_imm;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_illegal, out_pc
  );

endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational RV32I OP/OP-IMM instruction to decoded-record translator
// Ports: instr (raw instruction), pc (passed through), rec (decoded record; illegal flagged).
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output dec_rec_t        rec
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_sh;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_sh = {27'd0, instr[24:20]};

  logic            legal;
  logic [5:0]      op;
  logic            use_imm;
  logic [XLEN-1:0] imm;

  always_comb begin
    legal   = 1'b0;
    op      = ALU_NOP;
    use_imm = 1'b0;
    imm     = '0;

    if (opcode == OPC_OP_IMM) begin
      use_imm = 1'b1;
      imm     = imm_i;
      legal   = 1'b1;
      case (f3)
        3'b000: op = ALU_ADDI;
        3'b001: begin
          op    = ALU_SLLI;
          imm   = imm_sh;
          legal = (f7 == F7_ZERO);
        end
        3'b010: op = ALU_SLTI;
        3'b011: op = ALU_SLTIU;
        3'b100: op = ALU_XORI;
        3'b101: begin
          op    = (f7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
          imm   = imm_sh;
          legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        end
        3'b110: op = ALU_ORI;
        default: op = ALU_ANDI;
      endcase
    end else if (opcode == OPC_OP) begin
      if (f7 == F7_ZERO) begin
        legal = 1'b1;
        case (f3)
          3'b000: op = ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b101: op = ALU_SRL;
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end else if (f7 == F7_ALT) begin
        // Only sub and sra have an alternate-funct7 form.
        if (f3 == 3'b000) begin
          legal = 1'b1;
          op    = ALU_SUB;
        end else if (f3 == 3'b101) begin
          legal = 1'b1;
          op    = ALU_SRA;
        end
      end
    end
  end

  // Illegal records keep rs1/rs2/pc for diagnostics but zero everything else.
  always_comb begin
    rec         = '0;
    rec.rs1     = instr[19:15];
    rec.rs2     = instr[24:20];
    rec.pc      = pc;
    rec.illegal = 1'b1;
    if (legal) begin
      rec.alu_op  = op;
      rec.rd      = instr[11:7];
      rec.imm     = imm;
      rec.use_imm = use_imm;
      rec.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered decode stage with 2-entry skid buffer feeding the ALU
// Ports: clk, rst_n (async active-low), flush (sync discard of buffered entries),
//        bus (slave side: fetch handshake in, decoded record handshake out).
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_decode_stage_if.slave  bus
);

  dec_rec_t   dec;
  dec_rec_t   head_q;
  dec_rec_t   tail_q;
  buf_state_t state_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       push;
  logic       pop;

  alu_op_decoder u_dec (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .rec   (dec)
  );

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // head_q is always the oldest entry and drives out_*; tail_q only holds data in BUF_TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            head_q      <= dec;
            state_q     <= BUF_ONE;
            out_valid_q <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_q <= dec;
          end else if (push) begin
            tail_q     <= dec;
            state_q    <= BUF_TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_q     <= tail_q;
            state_q    <= BUF_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= BUF_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_alu_op  = head_q.alu_op;
  assign bus.out_rs1     = head_q.rs1;
  assign bus.out_rs2     = head_q.rs2;
  assign bus.out_rd      = head_q.rd;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_use_imm = head_q.use_imm;
  assign bus.out_illegal = head_q.illegal;
  assign bus.out_pc      = head_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - randomized self-checking bench for alu_decode_stage
module tb_alu_decode_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_decode_stage_if bus();

  alu_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference decoder: table lookup by funct3 plus legality rules.
  int imm_codes[8] = '{5, 6, 7, 8, 9, 10, 12, 13};
  int op_codes[8]  = '{18, 20, 21, 22, 23, 24, 26, 27};

  function automatic dec_rec_t model_dec(input logic [31:0] i, input logic [31:0] pc);
    dec_rec_t r;
    int f3, f7, opc, code;
    bit legal, is_shift;
    opc = int'(i[6:0]);
    f3  = int'(i[14:12]);
    f7  = int'(i[31:25]);
    r = '0;
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.pc  = pc;
    legal = 0;
    code  = 0;
    if (opc == 'h13) begin
      is_shift = (f3 == 1) || (f3 == 5);
      if (f3 == 1) legal = (f7 == 0);
      else if (f3 == 5) legal = (f7 == 0) || (f7 == 'h20);
      else legal = 1;
      code = imm_codes[f3] + ((f3 == 5 && f7 == 'h20) ? 1 : 0);
      if (legal) begin
        r.use_imm = 1'b1;
        if (is_shift) r.imm = 32'(i[24:20]);
        else r.imm = 32'(signed'(i[31:20]));
      end
    end else if (opc == 'h33) begin
      legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      code  = op_codes[f3] + ((f7 == 'h20) ? 1 : 0);
    end
    if (legal) begin
      r.alu_op = 6'(code);
      r.rd = i[11:7];
    end
    r.illegal = !legal;
    return r;
  endfunction

  // Model of the buffer: a queue of at most two records.
  dec_rec_t q[$];
  bit m_push, m_pop;
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_push = bus.in_valid && (q.size() < 2);
      m_pop  = (q.size() > 0) && bus.out_ready;
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(model_dec(bus.in_instr, bus.in_pc));
      end
    end
  end

  dec_rec_t dut_rec;
  assign dut_rec = {bus.out_alu_op, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm,
                    bus.out_use_imm, bus.out_illegal, bus.out_pc};

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.in_ready, (q.size() < 2));
      check("out_valid", bus.out_valid, (q.size() > 0));
      if (q.size() > 0) check("head_record", dut_rec, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send1(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input int op, input int rd, input int rs1, input int imm,
                     input bit use_imm, input bit ill);
    check({nm, "_valid"}, bus.out_valid, 1'b1);
    check({nm, "_op"}, bus.out_alu_op, 6'(op));
    check({nm, "_rd"}, bus.out_rd, 5'(rd));
    check({nm, "_rs1"}, bus.out_rs1, 5'(rs1));
    check({nm, "_imm"}, bus.out_imm, 32'(imm));
    check({nm, "_use_imm"}, bus.out_use_imm, use_imm);
    check({nm, "_illegal"}, bus.out_illegal, ill);
  endtask

  logic [31:0] b2b[5];
  dec_rec_t    mr;
  int          sent, cyc;
  bit          acc;
  logic [31:0] r;
  int          sel;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;

    // Pin the reference model with hand-decoded values.
    mr = model_dec(32'h40335293, 32'h0);
    check("model_srai_op", mr.alu_op, 6'd11);
    check("model_srai_imm", mr.imm, 32'd3);
    mr = model_dec(32'hFFF00093, 32'h0);
    check("model_addi_neg_imm", mr.imm, 32'hFFFFFFFF);
    mr = model_dec(32'h402091B3, 32'h0);
    check("model_sll_alt_illegal", mr.illegal, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_record", dut_rec, '0);
    rst_n = 1'b1;
    tick();

    // Single instructions with out_ready high.
    send1(32'h00500093, 32'h100); @(negedge clk);
    lit("addi", 5, 1, 0, 5, 1'b1, 1'b0);
    check("addi_pc", bus.out_pc, 32'h100);
    tick();
    send1(32'h402081B3, 32'h104); @(negedge clk);
    lit("sub", 19, 3, 1, 0, 1'b0, 1'b0);
    check("sub_rs2", bus.out_rs2, 5'd2);
    tick();
    send1(32'h002081B3, 32'h108); @(negedge clk);
    lit("add", 18, 3, 1, 0, 1'b0, 1'b0);
    tick();
    send1(32'h40335293, 32'h10C); @(negedge clk);
    lit("srai", 11, 5, 6, 3, 1'b1, 1'b0);
    tick();
    send1(32'h00000003, 32'h110); @(negedge clk);
    lit("load", 0, 0, 0, 0, 1'b0, 1'b1);
    tick();

    // Back-to-back stream with out_ready held low for 3 cycles.
    for (int k = 0; k < 5; k++) b2b[k] = {12'(k + 1), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 5 && cyc < 40) begin
      bus.in_instr = b2b[sent];
      bus.in_pc    = 32'h200 + 32'(4 * sent);
      if (cyc == 3) begin
        check("b2b_full_in_ready", bus.in_ready, 1'b0);
        check("b2b_accepted", sent, 2);
        check("b2b_head_rd", bus.out_rd, 5'd1);
        bus.out_ready = 1'b1;
      end
      acc = bus.in_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    check("b2b_all_sent", sent, 5);
    bus.in_valid = 1'b0;
    repeat (3) tick();

    // Flush while full with an instruction offered.
    bus.out_ready = 1'b0;
    send1(32'h00100093, 32'h300);
    send1(32'h00200113, 32'h304);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00700393;
    bus.in_pc    = 32'h308;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("flush_gone", bus.out_valid, 1'b0);
    end
    tick();

    // Asynchronous reset with one entry buffered.
    bus.out_ready = 1'b0;
    send1(32'h00900493, 32'h400);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_in_ready", bus.in_ready, 1'b1);
    check("rst_mid_record", dut_rec, '0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    send1(32'h00500093, 32'h500); @(negedge clk);
    lit("post_rst_addi", 5, 1, 0, 5, 1'b1, 1'b0);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) r[6:0] = 7'b0010011;
      else if (sel == 1) r[6:0] = 7'b0110011;
      else if (sel == 2) r[6:0] = 7'b0110011;
      if (sel != 3) begin
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h00;
          default: ;
        endcase
      end
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_instr  = r;
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
